// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and helpers for the 16-requester round-robin arbiter.
// Consumers: rr_prio_enc16 and rr_arbiter16 (which builds its hold timer only under RR_ARB_TIMEOUT_EN).
package rr_arb_pkg;

  localparam int N_REQ  = 16;
  localparam int ID_W   = 4;
  localparam int PTR_W  = ID_W;
  localparam int HOLD_W = 8;
  localparam int NIB_N  = N_REQ / 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Priority moves to the slot just after the releasing owner; 15 wraps to 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [ID_W-1:0] owner);
    next_ptr = PTR_W'(owner + 1'b1);
  endfunction

  // Lowest set bit of a 4-bit slice (caller guarantees the slice is non-zero).
  function automatic logic [1:0] nib_lsb(input logic [3:0] v);
    if (v[0])      nib_lsb = 2'd0;
    else if (v[1]) nib_lsb = 2'd1;
    else if (v[2]) nib_lsb = 2'd2;
    else           nib_lsb = 2'd3;
  endfunction

endpackage

// File: rtl/rr_prio_enc16.sv
// Masked 16-to-4 priority encoder: lowest set bit at or above i_ptr, else lowest set bit overall.
// Purely combinational; the caller registers the result.
module rr_prio_enc16
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_valid
);

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_masked;
  logic [N_REQ-1:0] w_sel;
  logic [NIB_N-1:0] w_nib_valid;
  logic [1:0]       w_nib_idx [NIB_N];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign w_mask[gi] = (5'(gi) >= {1'b0, i_ptr});
    end
  endgenerate

  assign w_masked = i_vec & w_mask;
  // Nothing at or above ptr means the search wraps to the unmasked vector.
  assign w_sel    = (|w_masked) ? w_masked : i_vec;
  assign o_valid  = |i_vec;

  generate
    for (gi = 0; gi < NIB_N; gi++) begin : g_nib
      assign w_nib_valid[gi] = |w_sel[4*gi +: 4];
      assign w_nib_idx[gi]   = nib_lsb(w_sel[4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    o_idx = '0;
    for (int n = NIB_N - 1; n >= 0; n--) begin
      if (w_nib_valid[n]) o_idx = {2'(n), w_nib_idx[n]};
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter: grant held until release, then priority rotates to owner+1.
// Optional RR_ARB_TIMEOUT_EN adds a MAX_HOLD-cycle forced release with a one-cycle timeout pulse.
module rr_arbiter16
  import rr_arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 8
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             busy,
  output logic             timeout
);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic [PTR_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [ID_W-1:0]  r_gnt_id;
  logic             r_gnt_valid;

  logic [ID_W-1:0]  w_win_idx;
  logic             w_win_valid;
  logic             w_owner_rel;
  logic             w_hold_expired;
  logic             w_load;
  logic             w_release;

  rr_prio_enc16 u_enc (
    .i_vec   (req),
    .i_ptr   (r_ptr),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  // Explicit release, or the owner dropped its request.
  assign w_owner_rel = rel || !req[r_gnt_id];

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_state_next = HOLD;
          w_load       = 1'b1;
        end
      end
      HOLD: begin
        if (w_owner_rel || w_hold_expired) begin
          w_state_next = IDLE;
          w_release    = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_gnt       <= N_REQ'(1) << w_win_idx;
        r_gnt_id    <= w_win_idx;
        r_gnt_valid <= 1'b1;
      end else if (w_release) begin
        r_gnt       <= '0;
        r_gnt_id    <= '0;
        r_gnt_valid <= 1'b0;
        r_ptr       <= next_ptr(r_gnt_id);
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_timeout;
  logic              w_force;

  assign w_hold_expired = (r_hold_cnt == HOLD_LAST);
  // A normal release on the same edge wins, so no timeout pulse then.
  assign w_force        = (r_state == HOLD) && !w_owner_rel && w_hold_expired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (w_load) begin
        r_hold_cnt <= '0;
      end else if ((r_state == HOLD) && !w_release) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_hold_expired = 1'b0;
  assign timeout        = 1'b0;
`endif

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign busy      = (r_state == HOLD);

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 with a cycle-level reference model and literal spot checks.
// Build with RR_ARB_TIMEOUT_EN to exercise the forced-release path (MAX_HOLD=4).
module tb_rr_arbiter16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        rel;
  logic [15:0] gnt;
  logic [3:0]  gnt_id;
  logic        gnt_valid;
  logic        busy;
  logic        timeout;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state: owner index (-1 = nobody), pointer, hold cycles.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int MAXH = 4;
  rr_arbiter16 #(.MAX_HOLD(MAXH)) dut (
`else
  rr_arbiter16 dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, want < 200000", $time);
    $fatal(1, "watchdog");
  end

  // Model: advance one clock using the inputs present at the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      m_to = 1'b0;
      if (rst_n !== 1'b1) begin
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
      end else if (m_owner < 0) begin
        for (int k = 0; k < 16; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 16] === 1'b1) begin
            m_owner = (m_ptr + k) % 16;
            m_cnt   = 0;
          end
        end
      end else if (rel === 1'b1 || req[m_owner] !== 1'b1) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
`ifdef RR_ARB_TIMEOUT_EN
      end else if (m_cnt == MAXH - 1) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
        m_to    = 1'b1;
`endif
      end else begin
        m_cnt++;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    logic [15:0] e_gnt;
    logic [3:0]  e_id;
    logic        e_v;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_v   = (m_owner >= 0);
        e_gnt = e_v ? (16'h0001 << m_owner) : 16'h0000;
        e_id  = e_v ? 4'(m_owner) : 4'd0;
        n_vec++;
        if (gnt !== e_gnt || gnt_id !== e_id || gnt_valid !== e_v ||
            busy !== e_v || timeout !== m_to) begin
          n_bad++;
          $display("FAIL model @%0t: got gnt=%h id=%0d v=%0b busy=%0b to=%0b, want gnt=%h id=%0d v=%0b busy=%0b to=%0b",
                   $time, gnt, gnt_id, gnt_valid, busy, timeout, e_gnt, e_id, e_v, e_v, m_to);
        end
      end
    end
  end

  task automatic step(input logic [15:0] r, input logic l);
    req = r;
    rel = l;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic v, input logic [3:0] id, input logic to);
    logic [15:0] e_gnt;
    logic [3:0]  e_id;
    e_id  = v ? id : 4'd0;
    e_gnt = v ? (16'h0001 << id) : 16'h0000;
    n_vec++;
    if (gnt_valid !== v || gnt_id !== e_id || gnt !== e_gnt || timeout !== to || busy !== v) begin
      n_bad++;
      $display("FAIL %s: got v=%0b id=%0d gnt=%h to=%0b busy=%0b, want v=%0b id=%0d gnt=%h to=%0b",
               name, gnt_valid, gnt_id, gnt, timeout, busy, v, e_id, e_gnt, to);
    end else begin
      $display("ok   %s: v=%0b id=%0d gnt=%h to=%0b", name, gnt_valid, gnt_id, gnt, timeout);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'hFFFF;
    rel   = 1'b0;
    @(negedge clk);

    // Reset with all requests asserted.
    step(16'hFFFF, 1'b0);
    chk_en = 1'b1;
    step(16'hFFFF, 1'b0);
    lit("reset", 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    step(16'hFFFF, 1'b0);
    lit("first_after_reset", 1'b1, 4'd0, 1'b0);
    step(16'h0000, 1'b0);
    lit("withdraw_id0", 1'b0, 4'd0, 1'b0);

    // Single requester, then ptr=6 wraps to id 0.
    step(16'h0020, 1'b0);
    lit("single_id5", 1'b1, 4'd5, 1'b0);
    step(16'h0020, 1'b1);
    lit("rel_id5", 1'b0, 4'd0, 1'b0);
    step(16'h0021, 1'b0);
    lit("wrap_ptr6", 1'b1, 4'd0, 1'b0);
    step(16'h0021, 1'b1);
    step(16'h0000, 1'b0);

    // Fairness from a fresh reset.
    rst_n = 1'b0;
    step(16'hFFFF, 1'b0);
    step(16'hFFFF, 1'b0);
    rst_n = 1'b1;
    for (int g = 0; g < 18; g++) begin
      step(16'hFFFF, 1'b0);
      lit($sformatf("fair_grant%0d", g), 1'b1, 4'(g % 16), 1'b0);
      step(16'hFFFF, 1'b1);
      lit($sformatf("fair_idle%0d", g), 1'b0, 4'd0, 1'b0);
    end

    // Wrap: grant 13 (ptr->14), then 0x0009 gives 0 then 3.
    step(16'h2000, 1'b0);
    lit("grant13", 1'b1, 4'd13, 1'b0);
    step(16'h2000, 1'b1);
    step(16'h0009, 1'b0);
    lit("wrap_to0", 1'b1, 4'd0, 1'b0);
    step(16'h0009, 1'b1);
    step(16'h0009, 1'b0);
    lit("then3", 1'b1, 4'd3, 1'b0);
    step(16'h0009, 1'b1);

    // Owner withdrawal, other requests ignored during hold, rel in IDLE.
    step(16'h0080, 1'b0);
    lit("grant7", 1'b1, 4'd7, 1'b0);
    step(16'h0180, 1'b0);
    lit("hold7_ignore8", 1'b1, 4'd7, 1'b0);
    step(16'h0100, 1'b0);
    lit("withdraw7", 1'b0, 4'd0, 1'b0);
    req = 16'h0000;
    step(16'h0000, 1'b1);
    lit("rel_in_idle", 1'b0, 4'd0, 1'b0);
    step(16'h0101, 1'b0);
    lit("ptr8_grant8", 1'b1, 4'd8, 1'b0);

    // Reset mid-grant drops the grant and clears ptr.
    rst_n = 1'b0;
    step(16'h0101, 1'b0);
    lit("reset_midgrant", 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    step(16'h0101, 1'b0);
    lit("ptr0_after_reset", 1'b1, 4'd0, 1'b0);
    step(16'h0000, 1'b0);

    // Hold limit behaviour.
    step(16'h0004, 1'b0);
    lit("hold_grant2", 1'b1, 4'd2, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
    for (int c = 1; c < MAXH; c++) begin
      step(16'h0004, 1'b0);
      lit($sformatf("hold_c%0d", c), 1'b1, 4'd2, 1'b0);
    end
    step(16'h0006, 1'b0);
    lit("timeout_pulse", 1'b0, 4'd0, 1'b1);
    step(16'h0006, 1'b0);
    lit("after_timeout_id1", 1'b1, 4'd1, 1'b0);
`else
    for (int c = 1; c < 7; c++) begin
      step(16'h0004, 1'b0);
      lit($sformatf("hold_c%0d", c), 1'b1, 4'd2, 1'b0);
    end
`endif
    step(16'h0000, 1'b0);
    lit("final_release", 1'b0, 4'd0, 1'b0);
    step(16'h0000, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
